// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns 40-bit SPI packets into single-word parameter-memory transactions. Optional STATS op: SPI_CMD_STATS_EN.
// Latency: mem_req rises 1 cycle after in_valid; read data appears in out_packet 1 cycle after mem_rvalid.
// Backpressure: none upstream; a packet arriving while a transaction is in flight is dropped and flagged as overrun.
module spi_cmd_decoder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 24
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                in_valid,
    input  logic [4+ADDR_WIDTH+DATA_WIDTH-1:0]  in_packet,
    output logic [4+ADDR_WIDTH+DATA_WIDTH-1:0]  out_packet,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [DATA_WIDTH-1:0]               mem_wdata,
    input  logic                                mem_ready,
    input  logic                                mem_rvalid,
    input  logic [DATA_WIDTH-1:0]               mem_rdata
);

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_WRITE   = 4'h1;
    localparam logic [3:0] OP_READ    = 4'h2;
    localparam logic [3:0] OP_WR_INC  = 4'h3;
    localparam logic [3:0] OP_RD_INC  = 4'h4;
    localparam logic [3:0] OP_SET_PTR = 4'h5;
    localparam logic [3:0] OP_CLR     = 4'hE;
`ifdef SPI_CMD_STATS_EN
    localparam logic [3:0] OP_STATS   = 4'hF;
`endif

    typedef struct packed {
        logic [3:0]            op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    pkt_t   pkt;
    state_t state, state_nxt;

    logic accept, drop, grant, rd_done;
    logic op_mem, op_wr, op_ptr, op_setp, op_clr, op_ill;
`ifdef SPI_CMD_STATS_EN
    logic op_stats;
    logic [11:0] pkt_cnt, ovr_cnt;
`endif

    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  inc_pend, ovr_flag, ill_flag, rdv;

    assign pkt = in_packet;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop      = 1'b0;
        grant     = 1'b0;
        rd_done   = 1'b0;
        op_mem    = 1'b0;
        op_wr     = 1'b0;
        op_ptr    = 1'b0;
        op_setp   = 1'b0;
        op_clr    = 1'b0;
        op_ill    = 1'b0;
`ifdef SPI_CMD_STATS_EN
        op_stats  = 1'b0;
`endif
        case (pkt.op)
            OP_NOP:     ;
            OP_WRITE:   begin op_mem = 1'b1; op_wr = 1'b1; end
            OP_READ:    op_mem = 1'b1;
            OP_WR_INC:  begin op_mem = 1'b1; op_wr = 1'b1; op_ptr = 1'b1; end
            OP_RD_INC:  begin op_mem = 1'b1; op_ptr = 1'b1; end
            OP_SET_PTR: op_setp = 1'b1;
            OP_CLR:     op_clr = 1'b1;
`ifdef SPI_CMD_STATS_EN
            OP_STATS:   op_stats = 1'b1;
`endif
            default:    op_ill = 1'b1;
        endcase

        // Packets are only accepted in IDLE; anything else, including the completion cycle, is an overrun.
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (op_mem) state_nxt = REQ;
                end
            end
            REQ: begin
                drop = in_valid;
                if (mem_ready) begin
                    grant     = 1'b1;
                    state_nxt = mem_we ? IDLE : RDWAIT;
                end
            end
            RDWAIT: begin
                drop = in_valid;
                if (mem_rvalid) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req    = (state == REQ);
    assign out_packet = {ovr_flag, ill_flag, state != IDLE, rdv, rd_addr, rd_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            inc_pend  <= 1'b0;
            ovr_flag  <= 1'b0;
            ill_flag  <= 1'b0;
            rdv       <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
        end else begin
            // A flag raised in the same cycle as CLR_STATUS survives the clear.
            ovr_flag <= drop | (ovr_flag & ~(accept & op_clr));
            ill_flag <= (accept & op_ill) | (ill_flag & ~(accept & op_clr));
            if (accept && op_mem) begin
                mem_we    <= op_wr;
                mem_addr  <= op_ptr ? ptr : pkt.addr;
                mem_wdata <= pkt.data;
                inc_pend  <= op_ptr;
                rdv       <= 1'b0;
            end
            if (accept && op_setp) ptr <= pkt.addr;
            if (grant && inc_pend) ptr <= ptr + ADDR_WIDTH'(1);
            if (rd_done) begin
                rdv     <= 1'b1;
                rd_addr <= mem_addr;
                rd_data <= mem_rdata;
            end
`ifdef SPI_CMD_STATS_EN
            if (accept && op_stats) begin
                rdv     <= 1'b0;
                rd_addr <= '0;
                rd_data <= DATA_WIDTH'({pkt_cnt, ovr_cnt});
            end
`endif
        end
    end

`ifdef SPI_CMD_STATS_EN
    // STATS reports the count before its own packet is added.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt <= '0;
            ovr_cnt <= '0;
        end else if (accept && op_clr) begin
            pkt_cnt <= '0;
            ovr_cnt <= '0;
        end else begin
            if (accept && pkt_cnt != 12'hFFF) pkt_cnt <= pkt_cnt + 12'd1;
            if (drop && ovr_cnt != 12'hFFF)   ovr_cnt <= ovr_cnt + 12'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed packets with literal expectations, then randomized traffic
// against a transaction-level model; every cycle the DUT outputs are compared to the model.
module tb_spi_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [39:0] in_packet;
    logic [39:0] out_packet;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [23:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    spi_cmd_decoder #(.ADDR_WIDTH(12), .DATA_WIDTH(24)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_packet  (in_packet),
        .out_packet (out_packet),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    // Model: one outstanding transaction record plus status/pointer state.
    bit          m_open, m_granted, m_we, m_inc, m_ovr, m_ill, m_rdv;
    logic [11:0] m_addr, m_ptr, m_raddr;
    logic [23:0] m_wdata, m_rdata;
`ifdef SPI_CMD_STATS_EN
    int          m_pkt, m_ovc;
`endif

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] exp_out();
        return {m_ovr, m_ill, m_open, m_rdv, m_raddr, m_rdata};
    endfunction

    task automatic model_reset();
        m_open = 0; m_granted = 0; m_we = 0; m_inc = 0;
        m_ovr = 0; m_ill = 0; m_rdv = 0;
        m_addr = '0; m_ptr = '0; m_raddr = '0; m_wdata = '0; m_rdata = '0;
`ifdef SPI_CMD_STATS_EN
        m_pkt = 0; m_ovc = 0;
`endif
    endtask

    task automatic model_step(input bit iv, input logic [39:0] p, input bit rdy, input bit rv,
                              input logic [23:0] rd);
        logic [3:0]  op;
        logic [11:0] a;
        logic [23:0] d;
        op = p[39:36];
        a  = p[35:24];
        d  = p[23:0];
        if (!m_open) begin
            if (iv) begin
                if (op >= 4'd1 && op <= 4'd4) begin
                    m_open = 1; m_granted = 0;
                    m_we   = (op == 4'd1 || op == 4'd3);
                    m_inc  = (op >= 4'd3);
                    m_addr = m_inc ? m_ptr : a;
                    m_wdata = d;
                    m_rdv  = 0;
                end else if (op == 4'd5) begin
                    m_ptr = a;
                end else if (op == 4'hE) begin
                    m_ovr = 0; m_ill = 0;
`ifdef SPI_CMD_STATS_EN
                end else if (op == 4'hF) begin
                    m_raddr = '0;
                    m_rdata = {m_pkt[11:0], m_ovc[11:0]};
                    m_rdv   = 0;
`endif
                end else if (op != 4'd0) begin
                    m_ill = 1;
                end
`ifdef SPI_CMD_STATS_EN
                if (op == 4'hE) begin m_pkt = 0; m_ovc = 0; end
                else if (m_pkt < 4095) m_pkt++;
`endif
            end
        end else begin
            if (iv) begin
                m_ovr = 1;
`ifdef SPI_CMD_STATS_EN
                if (m_ovc < 4095) m_ovc++;
`endif
            end
            if (!m_granted) begin
                if (rdy) begin
                    if (m_inc) m_ptr = m_ptr + 12'd1;
                    if (m_we) m_open = 0;
                    else      m_granted = 1;
                end
            end else if (rv) begin
                m_rdv = 1; m_raddr = m_addr; m_rdata = rd; m_open = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and return at negedge+1 after the edge.
    task automatic step(input bit iv, input logic [39:0] p, input bit rdy, input bit rv,
                        input logic [23:0] rd);
        in_valid = iv; in_packet = p; mem_ready = rdy; mem_rvalid = rv; mem_rdata = rd;
        model_step(iv, p, rdy, rv, rd);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_packet", out_packet, exp_out());
            check("mem_req", mem_req, m_open && !m_granted);
            if (m_open && !m_granted) begin
                check("mem_we", mem_we, m_we);
                check("mem_addr", mem_addr, m_addr);
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
            end
        end
    end

    initial begin
        logic [3:0] op_tbl [16];
        logic [3:0] op;
        logic [11:0] a;
        op_tbl = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4,
                   4'h5, 4'h5, 4'h0, 4'hE, 4'h7, 4'hF, 4'hB, 4'h2};
        reset_n = 1'b0; in_valid = 0; in_packet = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_out_packet", out_packet, 40'h0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // WRITE with immediate grant
        step(1, 40'h1_123_ABCDEF, 1, 0, 0);
        check("wr_req", mem_req, 1);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 12'h123);
        check("wr_wdata", mem_wdata, 24'hABCDEF);
        check("wr_busy", out_packet, 40'h2_000_000000);
        step(0, 0, 1, 0, 0);
        check("wr_done", mem_req, 0);
        check("wr_idle", out_packet, 40'h0);

        // READ with delayed grant and delayed data
        step(1, 40'h2_045_000000, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rd_hold_addr", mem_addr, 12'h045);
        step(0, 0, 1, 0, 0);
        check("rd_wait_req", mem_req, 0);
        check("rd_wait_busy", out_packet, 40'h2_000_000000);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 24'h5A5A5A);
        check("rd_data", out_packet, 40'h1_045_5A5A5A);

        // Pointer wrap
        step(1, 40'h5_FFF_000000, 0, 0, 0);
        step(1, 40'h3_000_000011, 0, 0, 0);
        check("winc0_addr", mem_addr, 12'hFFF);
        check("winc0_rdv_clr", out_packet, 40'h2_045_5A5A5A);
        step(0, 0, 1, 0, 0);
        step(1, 40'h3_000_000022, 0, 0, 0);
        check("winc1_addr", mem_addr, 12'h000);
        step(0, 0, 1, 0, 0);
        step(1, 40'h4_000_000000, 0, 0, 0);
        check("rinc_addr", mem_addr, 12'h001);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 24'h123456);
        check("rinc_data", out_packet, 40'h1_001_123456);

        // Overrun while waiting for read data
        step(1, 40'h2_010_000000, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 40'h1_555_000000, 0, 0, 0);
        check("ovr_no_req", mem_req, 0);
        check("ovr_flag", out_packet[39], 1);
        step(0, 0, 0, 1, 24'h00BEEF);
        check("ovr_rd", out_packet, 40'h9_010_00BEEF);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("ovr_sticky", out_packet, 40'h9_010_00BEEF);
        step(1, 40'hE_000_000000, 0, 0, 0);
        check("ovr_clr", out_packet, 40'h1_010_00BEEF);

        // Illegal opcode
        step(1, 40'h7_000_000000, 1, 0, 0);
        check("ill_no_req", mem_req, 0);
        check("ill_flag", out_packet, 40'h5_010_00BEEF);
        step(1, 40'hE_000_000000, 0, 0, 0);
        check("ill_clr", out_packet, 40'h1_010_00BEEF);

`ifdef SPI_CMD_STATS_EN
        repeat (4) step(1, 40'h0, 0, 0, 0);
        step(1, 40'h1_100_000001, 0, 0, 0);
        step(1, 40'h0, 1, 0, 0);
        step(1, 40'hF_000_000000, 0, 0, 0);
        check("stats", out_packet, 40'h8_000_005_001);
        step(1, 40'hE_000_000000, 0, 0, 0);
`endif

        // Reset asserted while a read request is pending
        step(1, 40'h2_0AB_000000, 0, 0, 0);
        check("rst_pre_req", mem_req, 1);
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_req_drop", mem_req, 0);
        check("rst_out_zero", out_packet, 40'h0);
        #1;
        reset_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        step(0, 0, 0, 1, 24'hFFFFFF);
        check("rst_rv_ignored", out_packet, 40'h0);
        check("rst_no_req", mem_req, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            op = op_tbl[$urandom_range(0, 15)];
            a  = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            step(($urandom_range(0, 2) == 0), {op, a, 24'($urandom)},
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 24'($urandom));
        end
        repeat (8) step(0, 0, 1, 1, 24'h0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
